// File: rtl/pwl_div_if.sv
// Operand and result handshakes between the divider datapath and the PWL reciprocal sequencer.
interface pwl_div_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic         err;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, err
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, err
   );
endinterface

// File: rtl/pwl_div_ctrl.sv
// Sequences one mantissa division: PWL reciprocal seed, Newton-Raphson refinement on a
// shared W x W multiplier, then quotient = dividend * reciprocal.
//
// state  | meaning
// IDLE   | ready for an operand pair
// WAIT_R | counting down PWL latency, captures the reciprocal seed
// NR_T   | t = d*r, latch e = 2 - t
// NR_R   | r = r*e (saturating), advance iteration count
// QUOT   | q = a*r, latch quotient and raise out_valid
// DONE   | hold result until out_ready
module pwl_div_ctrl #(
   parameter int MANT_WIDTH = 8,
   parameter int PWL_LAT    = 1,
   parameter int NR_ITERS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   pwl_div_if.slave              bus,
   output logic [MANT_WIDTH-1:0] recip_in,
   input  logic [MANT_WIDTH-1:0] recip_data,
   output logic                  busy
);
   localparam int W  = MANT_WIDTH;
   localparam int CW = (PWL_LAT < 2) ? 1 : $clog2(PWL_LAT + 1);
   localparam logic [1:0] ITER_LAST = (NR_ITERS > 0) ? 2'(NR_ITERS - 1) : 2'd0;

   typedef enum logic [2:0] {IDLE, WAIT_R, NR_T, NR_R, QUOT, DONE} state_t;

   state_t          state, state_nx;
   logic [W-1:0]    a_q, d_q, r_q, e_q, quot_q;
   logic            err_q, oval_q;
   logic [CW-1:0]   cnt;
   logic [1:0]      iter;

   logic [W-1:0]    mul_x, mul_y, r_nr;
   logic [2*W-1:0]  prod, e_full;
   logic            unused_bits;

   // One multiplier; the state selects which product this cycle forms.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state)
         NR_T:    begin mul_x = d_q; mul_y = r_q; end
         NR_R:    begin mul_x = r_q; mul_y = e_q; end
         QUOT:    begin mul_x = a_q; mul_y = r_q; end
         default: begin mul_x = '0;  mul_y = '0;  end
      endcase
   end

   assign prod        = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
   assign e_full      = -prod;
   assign r_nr        = prod[2*W-1] ? {W{1'b1}} : prod[2*W-2:W-1];
   assign unused_bits = ^{e_full[W-1:0], prod[W-2:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.in_ready = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) state_nx = bus.divisor[W-1] ? WAIT_R : DONE;
         end
         WAIT_R:  if (cnt == CW'(1)) state_nx = (NR_ITERS > 0) ? NR_T : QUOT;
         NR_T:    state_nx = NR_R;
         NR_R:    state_nx = (iter == ITER_LAST) ? QUOT : NR_T;
         QUOT:    state_nx = DONE;
         DONE:    if (oval_q && bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         d_q      <= '0;
         r_q      <= '0;
         e_q      <= '0;
         quot_q   <= '0;
         err_q    <= 1'b0;
         oval_q   <= 1'b0;
         cnt      <= '0;
         iter     <= '0;
         recip_in <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_q      <= bus.dividend;
               d_q      <= bus.divisor;
               recip_in <= bus.divisor;
               cnt      <= CW'(PWL_LAT);
               iter     <= '0;
               if (!bus.divisor[W-1]) begin
                  quot_q <= {W{1'b1}};
                  err_q  <= 1'b1;
               end
            end
            WAIT_R: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) r_q <= recip_data;
            end
            NR_T: e_q <= e_full[2*W-1:W];
            NR_R: begin
               r_q  <= r_nr;
               iter <= iter + 2'd1;
            end
            QUOT: begin
               quot_q <= prod[2*W-1:W];
               err_q  <= 1'b0;
               oval_q <= 1'b1;
            end
            DONE: begin
               // Error path enters DONE with out_valid low; it rises one edge later.
               if (!oval_q)            oval_q <= 1'b1;
               else if (bus.out_ready) oval_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_valid = oval_q;
   assign bus.quotient  = quot_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_pwl_div_ctrl.sv
// Directed bench for pwl_div_ctrl across three parameter sets sharing one clock and reset.
module tb_pwl_div_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ri_a, ri_b, ri_c;
   logic [7:0] rd_a, rd_b, rd_c;
   logic       busy_a, busy_b, busy_c;
   int         n_cmp = 0;
   int         n_bad = 0;

   pwl_div_if #(.W(8)) ifa ();
   pwl_div_if #(.W(8)) ifb ();
   pwl_div_if #(.W(8)) ifc ();

   pwl_div_ctrl #(.MANT_WIDTH(8), .PWL_LAT(1), .NR_ITERS(1)) u_a (
      .clk(clk), .rst(rst), .bus(ifa), .recip_in(ri_a), .recip_data(rd_a), .busy(busy_a));
   pwl_div_ctrl #(.MANT_WIDTH(8), .PWL_LAT(1), .NR_ITERS(0)) u_b (
      .clk(clk), .rst(rst), .bus(ifb), .recip_in(ri_b), .recip_data(rd_b), .busy(busy_b));
   pwl_div_ctrl #(.MANT_WIDTH(8), .PWL_LAT(3), .NR_ITERS(1)) u_c (
      .clk(clk), .rst(rst), .bus(ifc), .recip_in(ri_c), .recip_data(rd_c), .busy(busy_c));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] d);
      case (sel)
         0: begin ifa.in_valid = v; ifa.dividend = a; ifa.divisor = d; end
         1: begin ifb.in_valid = v; ifb.dividend = a; ifb.divisor = d; end
         default: begin ifc.in_valid = v; ifc.dividend = a; ifc.divisor = d; end
      endcase
   endtask

   task automatic set_rd(input int sel, input logic [7:0] v);
      case (sel)
         0: rd_a = v;
         1: rd_b = v;
         default: rd_c = v;
      endcase
   endtask

   task automatic set_or(input int sel, input logic v);
      case (sel)
         0: ifa.out_ready = v;
         1: ifb.out_ready = v;
         default: ifc.out_ready = v;
      endcase
   endtask

   task automatic sample(input int sel, output logic ir, output logic ov, output logic er,
                         output logic bz, output logic [7:0] q, output logic [7:0] ri);
      case (sel)
         0: begin ir = ifa.in_ready; ov = ifa.out_valid; er = ifa.err; bz = busy_a; q = ifa.quotient; ri = ri_a; end
         1: begin ir = ifb.in_ready; ov = ifb.out_valid; er = ifb.err; bz = busy_b; q = ifb.quotient; ri = ri_b; end
         default: begin ir = ifc.in_ready; ov = ifc.out_valid; er = ifc.err; bz = busy_c; q = ifc.quotient; ri = ri_c; end
      endcase
   endtask

   // recip_data carries the true reciprocal only ahead of edge k+lat_pwl; garbage otherwise.
   task automatic txn(input int sel, input int lat_pwl, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input logic [7:0] eq, input logic ee,
                      input int elat, input int hold);
      logic ir, ov, er, bz;
      logic [7:0] q, ri;
      int got;
      @(negedge clk);
      drive(sel, 1'b1, a, d);
      set_rd(sel, 8'h5A);
      sample(sel, ir, ov, er, bz, q, ri);
      check("in_ready_idle", 32'(ir), 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 8'h00, 8'h00);
      sample(sel, ir, ov, er, bz, q, ri);
      check("recip_in", 32'(ri), 32'(d));
      check("busy_after_accept", 32'(bz), 32'd1);
      got = 0;
      for (int j = 1; j <= 20 && got == 0; j++) begin
         set_rd(sel, (j == lat_pwl) ? rd : (8'h3C ^ 8'(j * 17)));
         @(posedge clk);
         @(negedge clk);
         sample(sel, ir, ov, er, bz, q, ri);
         if (ov) got = j;
      end
      check("latency", 32'(got), 32'(elat));
      check("quotient", 32'(q), 32'(eq));
      check("err", 32'(er), 32'(ee));
      check("in_ready_done", 32'(ir), 32'd0);
      for (int h = 0; h < hold; h++) begin
         drive(sel, 1'b1, 8'hFF, 8'h81);
         set_rd(sel, 8'h11);
         @(posedge clk);
         @(negedge clk);
         sample(sel, ir, ov, er, bz, q, ri);
         check("hold_valid", 32'(ov), 32'd1);
         check("hold_quotient", 32'(q), 32'(eq));
         check("hold_err", 32'(er), 32'(ee));
         check("hold_in_ready", 32'(ir), 32'd0);
         check("hold_busy", 32'(bz), 32'd1);
      end
      drive(sel, 1'b0, 8'h00, 8'h00);
      set_or(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_or(sel, 1'b0);
      sample(sel, ir, ov, er, bz, q, ri);
      check("post_hs_valid", 32'(ov), 32'd0);
      check("post_hs_in_ready", 32'(ir), 32'd1);
      check("post_hs_busy", 32'(bz), 32'd0);
      @(posedge clk);
      @(negedge clk);
      sample(sel, ir, ov, er, bz, q, ri);
      check("no_extra_valid", 32'(ov), 32'd0);
      check("no_extra_busy", 32'(bz), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ir, ov, er, bz;
      logic [7:0] q, ri;
      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);
      drive(2, 1'b0, 8'h00, 8'h00);
      set_or(0, 1'b0); set_or(1, 1'b0); set_or(2, 1'b0);
      set_rd(0, 8'h00); set_rd(1, 8'h00); set_rd(2, 8'h00);

      #12;
      sample(0, ir, ov, er, bz, q, ri);
      check("rst_in_ready", 32'(ir), 32'd1);
      check("rst_out_valid", 32'(ov), 32'd0);
      check("rst_quotient", 32'(q), 32'd0);
      check("rst_err", 32'(er), 32'd0);
      check("rst_busy", 32'(bz), 32'd0);
      check("rst_recip_in", 32'(ri), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic: 0x60 / 0xC0 with seed 0xAA; NR keeps r at 0xAA.
      txn(0, 1, 8'h60, 8'hC0, 8'hAA, 8'h3F, 1'b0, 4, 0);
      // Seed refined 0xE0 -> 0xFC.
      txn(0, 1, 8'h80, 8'h80, 8'hE0, 8'h7E, 1'b0, 4, 0);
      // No refinement: quotient straight from seed.
      txn(1, 1, 8'h80, 8'h80, 8'hE0, 8'h70, 1'b0, 2, 0);
      // Unnormalized divisor.
      txn(0, 1, 8'h33, 8'h40, 8'hAA, 8'hFF, 1'b1, 1, 0);
      txn(1, 1, 8'h55, 8'h7F, 8'hE0, 8'hFF, 1'b1, 1, 0);
      // Backpressure with a stray in_valid during DONE.
      txn(0, 1, 8'h60, 8'hC0, 8'hAA, 8'h3F, 1'b0, 4, 5);
      // Longer PWL latency, seed only valid at the capture edge.
      txn(2, 3, 8'h60, 8'hC0, 8'hAA, 8'h3F, 1'b0, 6, 0);

      // Abort during NR_T; quotient currently 0x3F so its clearing is visible.
      @(negedge clk);
      drive(0, 1'b1, 8'h60, 8'hC0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 8'h00);
      set_rd(0, 8'hAA);
      @(posedge clk);
      @(negedge clk);
      sample(0, ir, ov, er, bz, q, ri);
      check("pre_abort_busy", 32'(bz), 32'd1);
      rst = 1'b1;
      #1;
      sample(0, ir, ov, er, bz, q, ri);
      check("abort_in_ready", 32'(ir), 32'd1);
      check("abort_out_valid", 32'(ov), 32'd0);
      check("abort_quotient", 32'(q), 32'd0);
      check("abort_err", 32'(er), 32'd0);
      check("abort_busy", 32'(bz), 32'd0);
      check("abort_recip_in", 32'(ri), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(0, 1, 8'h60, 8'hC0, 8'hAA, 8'h3F, 1'b0, 4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
